piano_frame_writer: RTL and testbench
=====================================

Name: piano_frame_writer

Overview:
Sequential sweep engine that renders the 77x60 piano image into the pixel frame buffer. It steps (x, y) across the grid and drives the combinational piano key/colour lookup. It answers that lookup's key-playing query from a frame-stable snapshot of the note state, and streams each returned colour into the frame buffer write port with back-pressure. The block sits between the note/voice state (upstream) and the frame buffer RAM (downstream), with the piano lookup as its combinational co-stage.

Parameters:
WIDTH, 77, grid columns (x = 0..WIDTH-1)
HEIGHT, 60, grid rows (y = 0..HEIGHT-1)
ADDR_W, 13, frame buffer address width (WIDTH*HEIGHT = 4620 words)
NUM_KEYS, 12, number of valid key indices

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request one full-frame render; sampled only in IDLE
keys_playing  input  NUM_KEYS  bit k = key k currently sounding
busy  output  1  high from the cycle after start is accepted through the last write
done  output  1  one-cycle pulse after the final pixel is written
x  output  7  column presented to the lookup
y  output  6  row presented to the lookup
key_requested  input  5  key index returned by the lookup for (x, y)
color  input  3  pixel colour returned by the lookup for (x, y)
is_key_playing  output  1  snapshot bit for key_requested
wr_en  output  1  frame buffer write strobe
wr_addr  output  ADDR_W  frame buffer word address, equal to y*WIDTH + x
wr_data  output  3  pixel colour written to the frame buffer
wr_ready  input  1  frame buffer can accept a write this cycle

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (reset_n). Assertion forces the following immediately, with no clock required: state IDLE, x=0, y=0, addr=0, snapshot=0, busy=0, done=0, wr_en=0.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - When start=1, latch keys_playing into the snapshot register and clear x, y and addr to 0. Next state is SWEEP.
  - start=0 holds IDLE.
- SWEEP:
  - busy=1.
  - wr_en = wr_ready (combinational). wr_addr = addr, wr_data = color.
  - On each cycle with wr_en=1:
    - x<WIDTH-1: x increments.
    - x=WIDTH-1: x wraps to 0 and y increments.
    - addr increments by 1 in every case. Use counters only; no multiplier.
  - When the write at x=WIDTH-1 and y=HEIGHT-1 (addr 4619) completes, next state is DONE.
  - wr_ready=0 is a stall: x, y and addr hold, and wr_en=0. There is no stall limit.
- DONE: done=1 and busy=0 for exactly one cycle, wr_en=0. Next state is IDLE.
- Timing: with wr_ready held high, SWEEP lasts exactly 4620 cycles and done appears on the cycle after the last write. A new start is accepted at the earliest on the cycle after done.
- is_key_playing (combinational) = snapshot[key_requested] when key_requested < NUM_KEYS, otherwise 0.
- Snapshot stability: the snapshot is frozen for the whole frame. keys_playing changes during SWEEP do not affect the current frame; the next frame picks them up.
- start during SWEEP or DONE is ignored and is not queued.
- Outside SWEEP: x and y hold their last values, and wr_data still follows color, but wr_en=0.
- Reset mid-frame: the frame is abandoned with no done pulse. The buffer keeps whatever was written; the next start rewrites it from addr 0.

Test Plan:
- Reset then start with keys_playing=0, wr_ready=1 -> 4620 writes at addrs 0..4619, one per cycle. addr 3465 (x=0, y=45) has data 3'h7. addr 1550 (x=10, y=20) has data 3'h0. done pulses once, cycle 4621 after acceptance.
- keys_playing=12'h002 (key 1) -> addr 1550 data 3'h4. addr 3465 data 3'h7. Key 11 pixel (x=76, y=59, addr 4619) data 3'h7.
- Toggle keys_playing to 12'hFFF at addr 2000 mid-sweep -> all writes of this frame still use 12'h002. The next frame writes addr 3465 as 3'h4.
- wr_ready pseudo-random at 50% duty -> no duplicate or skipped address, and wr_en never asserted while wr_ready=0. done follows the 4620th accepted write.
- Pulse start at addr 100 and during the DONE cycle -> no restart and exactly 4620 writes. start on the cycle after done -> new frame begins at addr 0.
- Drop reset_n at addr 3000 -> busy, wr_en, x, y and addr are 0 immediately with no done pulse. A fresh start completes a full 4620-write frame.

Source files
------------

// File: rtl/piano_frame_writer.sv
// Sweeps the 77x60 piano grid once per start, feeding the piano lookup and
// streaming its colours into the frame buffer under wr_ready back-pressure.
module piano_frame_writer #(
    parameter int WIDTH    = 77,
    parameter int HEIGHT   = 60,
    parameter int ADDR_W   = 13,
    parameter int NUM_KEYS = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [NUM_KEYS-1:0] keys_playing,
    output logic                busy,
    output logic                done,
    output logic [6:0]          x,
    output logic [5:0]          y,
    input  logic [4:0]          key_requested,
    input  logic [2:0]          color,
    output logic                is_key_playing,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [2:0]          wr_data,
    input  logic                wr_ready
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    localparam logic [6:0] X_LAST = 7'(WIDTH - 1);
    localparam logic [5:0] Y_LAST = 6'(HEIGHT - 1);

    state_t              state, state_nxt;
    logic [6:0]          x_q;
    logic [5:0]          y_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [NUM_KEYS-1:0] snap;
    logic [31:0]         snap_ext;
    logic                last_px;

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        wr_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SWEEP;
            end
            S_SWEEP: begin
                busy  = 1'b1;
                wr_en = wr_ready;
                if (wr_ready && last_px) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address is tracked alongside x/y so no y*WIDTH product is needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
            snap   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                snap   <= keys_playing;
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end else if (wr_en) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + 6'd1;
                end else begin
                    x_q <= x_q + 7'd1;
                end
            end
        end
    end

    // Zero-extend so any 5-bit key index selects a defined bit.
    assign snap_ext       = {{(32-NUM_KEYS){1'b0}}, snap};
    assign is_key_playing = (32'(key_requested) < NUM_KEYS) ? snap_ext[key_requested] : 1'b0;

    assign x       = x_q;
    assign y       = y_q;
    assign wr_addr = addr_q;
    assign wr_data = color;

endmodule

// File: tb/tb_piano_frame_writer.sv
// Directed bench for piano_frame_writer: models the piano lookup, scoreboards
// every write and spot-checks known pixels of each rendered frame.
module tb_piano_frame_writer;

    localparam int NPIX = 4620;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] keys_playing = '0;
    logic        busy, done, is_key_playing, wr_en;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [4:0]  key_requested;
    logic [2:0]  color, wr_data;
    logic [12:0] wr_addr;
    logic        wr_ready = 1'b1;

    int total = 0;
    int bad = 0;

    piano_frame_writer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .keys_playing(keys_playing),
        .busy(busy), .done(done), .x(x), .y(y), .key_requested(key_requested),
        .color(color), .is_key_playing(is_key_playing), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    // Lookup model: row 0 is an out-of-range border key, row 1 uses keys 12..31,
    // elsewhere key = x*12/77; odd keys in rows 2..39 are black.
    function automatic logic [4:0] lk_key(int xi, int yi);
        if (yi == 0) return 5'd31;
        if (yi == 1) return 5'(12 + xi % 20);
        return 5'((xi * 12) / 77);
    endfunction

    function automatic logic [2:0] lk_col(int xi, int yi, logic play);
        logic [4:0] k;
        k = lk_key(xi, yi);
        if (play) return 3'h4;
        if (yi >= 2 && yi < 40 && k[0]) return 3'h0;
        return 3'h7;
    endfunction

    assign key_requested = lk_key(int'(x), int'(y));
    assign color         = lk_col(int'(x), int'(y), is_key_playing);

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int         frame;
        int         addr;
        logic [2:0] data;
    } spot_t;
    spot_t spots[20];

    logic [2:0]  mem [0:NPIX-1];
    int          cyc = 0;
    logic        armed = 1'b0;
    logic [11:0] exp_snap = '0;
    int          exp_addr = 0, ex = 0, ey = 0, nwr = 0, ndone = 0;
    int          acc_cyc = 0, last_wr_cyc = 0;
    logic        rdy_mode = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        wr_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard, sampled on the falling edge.
    initial forever begin
        logic [4:0] k;
        logic       play;
        @(negedge clk);
        if (armed) begin
            if (done) begin
                chk("done_count", nwr, NPIX);
                chk("done_gap", cyc - last_wr_cyc, 1);
                if (!rdy_mode) chk("done_latency", cyc - acc_cyc, NPIX);
                chk("busy_in_done", int'(busy), 0);
                chk("en_in_done", int'(wr_en), 0);
                ndone++;
                armed = 1'b0;
            end else begin
                chk("busy_sweep", int'(busy), 1);
                if (!wr_ready) chk("en_while_stalled", int'(wr_en), 0);
                if (wr_en) begin
                    k    = lk_key(ex, ey);
                    play = (k < 5'd12) ? exp_snap[k[3:0]] : 1'b0;
                    chk("wr_addr", int'(wr_addr), exp_addr);
                    chk("xy", int'(x) * 100 + int'(y), ex * 100 + ey);
                    chk("wr_data", int'(wr_data), int'(lk_col(ex, ey, play)));
                    if (wr_addr < 13'(NPIX)) mem[wr_addr] = wr_data;
                    exp_addr++;
                    nwr++;
                    last_wr_cyc = cyc;
                    if (ex == 76) begin
                        ex = 0;
                        ey++;
                    end else begin
                        ex++;
                    end
                end
            end
        end else begin
            chk("idle_quiet", int'({wr_en, done, busy}), 0);
        end
    end

    task automatic arm(logic [11:0] keys);
        armed    = 1'b1;
        exp_snap = keys;
        exp_addr = 0;
        ex       = 0;
        ey       = 0;
        nwr      = 0;
        acc_cyc  = cyc;
    endtask

    task automatic do_start(logic [11:0] keys);
        @(posedge clk);
        #1;
        keys_playing = keys;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        arm(keys);
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_addr(int a);
        int n = 0;
        while (exp_addr < a && n < 20000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_addr < a) chk("addr_timeout", exp_addr, a);
    endtask

    task automatic check_spots(int f);
        foreach (spots[i])
            if (spots[i].frame == f)
                chk($sformatf("spot_f%0d_a%0d", f, spots[i].addr),
                    int'(mem[spots[i].addr]), int'(spots[i].data));
    endtask

    initial begin
        int nd;
        spots[0]  = '{0, 3465, 3'h7};
        spots[1]  = '{0, 1550, 3'h0};
        spots[2]  = '{0, 4619, 3'h7};
        spots[3]  = '{0,    0, 3'h7};
        spots[4]  = '{1, 1550, 3'h4};
        spots[5]  = '{1, 3465, 3'h7};
        spots[6]  = '{1, 4619, 3'h7};
        spots[7]  = '{2, 1550, 3'h4};
        spots[8]  = '{2, 3465, 3'h7};
        spots[9]  = '{2, 2500, 3'h0};
        spots[10] = '{3, 3465, 3'h4};
        spots[11] = '{3,   80, 3'h7};
        spots[12] = '{3,    0, 3'h7};
        spots[13] = '{3, 1550, 3'h4};
        spots[14] = '{4, 1550, 3'h0};
        spots[15] = '{5, 4619, 3'h4};
        spots[16] = '{5, 3465, 3'h7};
        spots[17] = '{7, 3465, 3'h7};
        spots[18] = '{7, 1550, 3'h0};
        spots[19] = '{7, 4619, 3'h7};

        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_addr", int'(wr_addr), 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        do_start(12'h000); wait_done(6000); check_spots(0);
        do_start(12'h002); wait_done(6000); check_spots(1);

        do_start(12'h002);
        wait_addr(2000);
        keys_playing = 12'hFFF;
        wait_done(6000); check_spots(2);

        rdy_mode = 1'b1;
        do_start(12'hFFF); wait_done(30000);
        rdy_mode = 1'b0;
        check_spots(3);

        // Start pulses mid-sweep and in the done cycle must be ignored.
        do_start(12'h000);
        wait_addr(100);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(6000);
        check_spots(4);
        start = 1'b1;
        keys_playing = 12'h800;
        @(posedge clk);
        #1;
        chk("no_restart_from_done", int'(busy), 0);
        @(posedge clk);
        #1 start = 1'b0;
        arm(12'h800);
        wait_done(6000); check_spots(5);

        // Reset mid-frame.
        do_start(12'h000);
        wait_addr(3000);
        nd = ndone;
        #1 reset_n = 1'b0;
        armed = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_wr_en", int'(wr_en), 0);
        chk("mid_rst_x", int'(x), 0);
        chk("mid_rst_y", int'(y), 0);
        chk("mid_rst_addr", int'(wr_addr), 0);
        chk("mid_rst_done", int'(done), 0);
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("no_done_after_rst", ndone, nd);

        do_start(12'h000); wait_done(6000); check_spots(7);
        chk("frames_done", ndone, 7);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
